// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start/data/parity/stop bit timing, checker strobes and frame verdict.
// Optional build macro UART_RX_FRAME_ERR_EN adds the framing_err output.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      Start_glitch,
  input  logic                      Par_err,
  input  logic                      Stp_err,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [3:0]                bit_cnt,
  output logic                      dat_samp_en,
  output logic                      strt_chk_en,
  output logic                      par_chk_en,
  output logic                      stp_chk_en,
  output logic                      deser_en,
  output logic                      data_valid
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic                      framing_err
`endif
);

  // state   | meaning
  // IDLE    | line idle, counters cleared, waiting for RX_IN low
  // START   | timing the start bit, glitch verdict at end of bit
  // DATA    | timing data bits 1..DATA_WIDTH
  // PARITY  | timing the parity bit, parity verdict latched at end of bit
  // STOP    | timing the stop bit
  // DONE    | single-cycle frame verdict, may chain straight into START
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

  state_t                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
  logic [3:0]                bit_q, bit_d;
  logic                      par_flag_q, par_flag_d;

  logic [PRESCALE_WIDTH-1:0] last_edge;
  logic [PRESCALE_WIDTH-1:0] chk_edge;
  logic                      bit_end;
  logic                      chk_now;

  assign last_edge = prescale_q - PRESCALE_WIDTH'(1);
  assign chk_edge  = (prescale_q >> 1) + PRESCALE_WIDTH'(2);
  assign bit_end   = (edge_q == last_edge);
  assign chk_now   = (edge_q == chk_edge);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      prescale_q <= '0;
      edge_q     <= '0;
      bit_q      <= '0;
      par_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prescale_q <= prescale_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      par_flag_q <= par_flag_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prescale_d  = prescale_q;
    edge_d      = edge_q;
    bit_d       = bit_q;
    par_flag_d  = par_flag_q;
    dat_samp_en = 1'b0;
    strt_chk_en = 1'b0;
    deser_en    = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    framing_err = 1'b0;
`endif

    if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP}) begin
      dat_samp_en = 1'b1;
      if (bit_end) begin
        edge_d = '0;
        bit_d  = bit_q + 4'd1;
      end else begin
        edge_d = edge_q + PRESCALE_WIDTH'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (!RX_IN) state_d = S_START;
      end
      S_START: begin
        strt_chk_en = chk_now;
        if (bit_end) state_d = Start_glitch ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        deser_en = chk_now;
        if (bit_end && bit_q == LAST_DATA_BIT) state_d = PAR_EN ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        par_chk_en = chk_now;
        if (bit_end) begin
          par_flag_d = Par_err;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        stp_chk_en = chk_now;
        if (bit_end) state_d = S_DONE;
      end
      S_DONE: begin
        data_valid = !(par_flag_q || Stp_err);
`ifdef UART_RX_FRAME_ERR_EN
        framing_err = par_flag_q || Stp_err;
`endif
        state_d = RX_IN ? S_IDLE : S_START;
      end
      default: state_d = S_IDLE;
    endcase

    // A new frame (from IDLE or chained from DONE) snapshots its bit period here.
    if (state_d == S_START && (state_q == S_IDLE || state_q == S_DONE)) begin
      prescale_d = Prescale;
      par_flag_d = 1'b0;
      edge_d     = '0;
      bit_d      = '0;
    end
    if (state_d == S_IDLE || state_d == S_DONE) begin
      edge_d = '0;
      bit_d  = '0;
    end
  end

  assign edge_cnt = edge_q;
  assign bit_cnt  = bit_q;

endmodule
